// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered 8N1 UART transmitter; define UART_TX_FIFO_PARITY_EN for an even parity bit
module uart_tx_fifo #(
    parameter int CLK_HZ       = 100000000,
    parameter int BIT_RATE     = 115200,
    parameter int PAYLOAD_BITS = 8,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [PAYLOAD_BITS-1:0]       s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic                          uart_txd,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int CPB = CLK_HZ / BIT_RATE;
    localparam int CW  = CPB > 1 ? $clog2(CPB) : 1;
    localparam int BW  = $clog2(PAYLOAD_BITS + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST_CYC = CW'(CPB - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(PAYLOAD_BITS - 1);
    localparam logic [AW:0]   FULL     = (AW + 1)'(FIFO_DEPTH);

`ifdef UART_TX_FIFO_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam state_t AFTER_DATA = PARITY;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
    localparam state_t AFTER_DATA = STOP;
`endif

    state_t                  state_q, state_d;
    logic [CW-1:0]           cyc_q, cyc_d;
    logic [BW-1:0]           bit_q, bit_d;
    logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]             count_q, count_d;
    logic                    txd_q, txd_d;
    logic [PAYLOAD_BITS-1:0] mem_q [FIFO_DEPTH];
    logic                    push, pop, tick;
`ifdef UART_TX_FIFO_PARITY_EN
    logic                    parity_q, parity_d;
`endif

    assign s_ready    = count_q != FULL;
    assign fifo_count = count_q;
    assign tx_busy    = (state_q != IDLE) || (count_q != '0);
    assign uart_txd   = txd_q;

    // FIFO storage: payload needs no reset, only the pointers do
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= s_data;
    end

    // FIFO pointer and occupancy bookkeeping
    always_comb begin
        push     = s_valid && s_ready;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
    end

    // Frame sequencing: bit-period timing, shifting and FIFO pops
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        tick    = cyc_q == LAST_CYC;
        cyc_d   = (state_q == IDLE || tick) ? '0 : cyc_q + CW'(1);
        case (state_q)
            IDLE:  pop = count_q != '0;
            START: state_d = tick ? DATA : START;
            DATA: begin
                if (tick && bit_q == LAST_BIT) begin
                    state_d = AFTER_DATA;
                end else if (tick) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + BW'(1);
                end
            end
`ifdef UART_TX_FIFO_PARITY_EN
            PARITY: state_d = tick ? STOP : PARITY;
`endif
            STOP: begin
                pop     = tick && count_q != '0;
                state_d = tick ? IDLE : STOP;
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            state_d = START;
            shift_d = mem_q[rd_ptr_q];
            bit_d   = '0;
        end
    end

    // Line level follows the next state so uart_txd comes straight from a flop
    always_comb begin
        txd_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
`ifdef UART_TX_FIFO_PARITY_EN
        parity_d = pop ? ^mem_q[rd_ptr_q] : parity_q;
        if (state_d == PARITY) txd_d = parity_d;
`endif
    end

    // State registers; reset aborts any frame and drops queued bytes
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cyc_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            txd_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            txd_q    <= txd_d;
        end
    end

`ifdef UART_TX_FIFO_PARITY_EN
    // Parity of the byte in flight, captured when it leaves the FIFO
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) parity_q <= 1'b0;
        else parity_q <= parity_d;
    end
`endif
endmodule
